seg7_scan_controller: RTL and testbench

SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

---
 rtl/seg7_pkg.sv | 54 +++++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_scan_controller.sv | 116 +++++++++++
 tb/tb_seg7_scan_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit ordering, hex glyph table
// and output polarity helper, reusable by any display block.
package seg7_pkg;

    // Segment ordering on the bus: bit6 = g ... bit0 = a.
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg7_t;

    localparam logic [6:0] SEG_BLANK_AL = 7'b1111111;

    function automatic logic [6:0] hex_glyph_al(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            4'hF:    glyph = 7'b0001110;
            default: glyph = SEG_BLANK_AL;
        endcase
        return glyph;
    endfunction

    // Glyphs are stored active-low; active-high boards get the inverse.
    function automatic logic [6:0] seg_polarity(input logic [6:0] glyph_al,
                                                input logic       active_low);
        logic [6:0] result;
        if (active_low) begin
            result = glyph_al;
        end else begin
            result = ~glyph_al;
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph decoder with selectable output polarity.
module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] nibble,
    output seg7_t      glyph
);

    assign glyph = seg7_t'(seg_polarity(hex_glyph_al(nibble), ACTIVE_LOW != 0));

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed seven-segment scanner: shadow-registered digit data,
// per-slot blanking window against ghosting, fully registered outputs.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [4*NUM_DIGITS-1:0]                             digits_in,
    input  logic [NUM_DIGITS-1:0]                               digit_en,
    input  logic [NUM_DIGITS-1:0]                               dp_in,
    input  logic                                                load,
    output logic [NUM_DIGITS-1:0]                               anode,
    output logic [6:0]                                          seg_out,
    output logic                                                dp_out,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] slot_idx
);

    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      SHOW_START = CNT_W'(BLANK_CYCLES);
    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
    localparam logic                  POL_LOW    = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = {NUM_DIGITS{POL_LOW}};
    localparam logic [6:0]            SEG_OFF    = seg_polarity(SEG_BLANK_AL, POL_LOW);

    logic [CNT_W-1:0]        cnt_r;
    logic [SLOT_W-1:0]       slot_r;
    logic [4*NUM_DIGITS-1:0] shadow_digits_r;
    logic [NUM_DIGITS-1:0]   shadow_en_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [NUM_DIGITS-1:0]   anode_r;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic [SLOT_W-1:0]       slot_idx_r;

    logic [3:0]              nibble_s;
    seg7_t                   glyph_s;
    logic                    lit_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [NUM_DIGITS-1:0]   anode_d_s;
    logic [6:0]              seg_d_s;
    logic                    dp_d_s;

    seg7_hex_decode #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_decode (
        .nibble(nibble_s),
        .glyph (glyph_s)
    );

    // Next-cycle output values derived from the current slot, phase and shadow data.
    always_comb begin
        nibble_s = shadow_digits_r[{slot_r, 2'b00} +: 4];
        lit_s    = (cnt_r >= SHOW_START) && shadow_en_r[slot_r];
        onehot_s = {NUM_DIGITS{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot_s[i] = lit_s && (slot_r == SLOT_W'(i));
        end
        anode_d_s = onehot_s ^ ANODE_OFF;
        dp_d_s    = (lit_s && shadow_dp_r[slot_r]) ^ POL_LOW;
        if (lit_s) begin
            seg_d_s = glyph_s;
        end else begin
            seg_d_s = SEG_OFF;
        end
    end

    // Slot timing, shadow capture and output registers; reset overrides load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r           <= {CNT_W{1'b0}};
            slot_r          <= {SLOT_W{1'b0}};
            shadow_digits_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_en_r     <= {NUM_DIGITS{1'b0}};
            shadow_dp_r     <= {NUM_DIGITS{1'b0}};
            anode_r         <= ANODE_OFF;
            seg_r           <= SEG_OFF;
            dp_r            <= POL_LOW;
            slot_idx_r      <= {SLOT_W{1'b0}};
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r  <= {CNT_W{1'b0}};
                slot_r <= (slot_r == SLOT_LAST) ? {SLOT_W{1'b0}} : slot_r + SLOT_W'(1);
            end else begin
                cnt_r  <= cnt_r + CNT_W'(1);
                slot_r <= slot_r;
            end
            if (load) begin
                shadow_digits_r <= digits_in;
                shadow_en_r     <= digit_en;
                shadow_dp_r     <= dp_in;
            end else begin
                shadow_digits_r <= shadow_digits_r;
                shadow_en_r     <= shadow_en_r;
                shadow_dp_r     <= shadow_dp_r;
            end
            anode_r    <= anode_d_s;
            seg_r      <= seg_d_s;
            dp_r       <= dp_d_s;
            slot_idx_r <= slot_r;
        end
    end

    assign anode    = anode_r;
    assign seg_out  = seg_r;
    assign dp_out   = dp_r;
    assign slot_idx = slot_idx_r;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: cycle-age reference model for a 4-digit
// active-low instance plus a glyph sweep on a 1-digit active-high instance.
module tb_seg7_scan_controller;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int PERIOD = ND * RD;

    logic        clk;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  anode;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [1:0]  slot_idx;

    logic [3:0]  digits1;
    logic        en1;
    logic        dpin1;
    logic        load1;
    logic        anode1;
    logic [6:0]  seg1;
    logic        dpout1;
    logic        slot1;

    int total;
    int bad;

    seg7_scan_controller #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .digit_en(digit_en),
        .dp_in(dp_in), .load(load), .anode(anode), .seg_out(seg_out),
        .dp_out(dp_out), .slot_idx(slot_idx)
    );

    seg7_scan_controller #(
        .NUM_DIGITS(1), .REFRESH_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(0)
    ) dut1 (
        .clk(clk), .rst(rst), .digits_in(digits1), .digit_en(en1),
        .dp_in(dpin1), .load(load1), .anode(anode1), .seg_out(seg1),
        .dp_out(dpout1), .slot_idx(slot1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: cycles elapsed since reset plus the loaded digit data.
    int          age;
    logic [3:0]  m_dig [ND];
    logic        m_en  [ND];
    logic        m_dp  [ND];

    logic [6:0] glyph_al [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] slot;
    } exp_t;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg_hi;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (age %0d, t=%0t)", name, act, want, age, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   phase;
        int   s;
        logic lit;
        phase = age % RD;
        s     = (age / RD) % ND;
        lit   = (phase >= BC) && m_en[s];
        e.slot  = 2'(s);
        e.anode = lit ? ~(4'b0001 << s) : 4'b1111;
        e.seg   = lit ? glyph_al[m_dig[s]] : 7'b1111111;
        e.dp    = ~(lit && m_dp[s]);
        return e;
    endfunction

    // One clock: predict, advance the model, then compare after the edge.
    task automatic tick();
        exp_t e;
        if (rst) begin
            e.anode = 4'b1111;
            e.seg   = 7'b1111111;
            e.dp    = 1'b1;
            e.slot  = 2'd0;
            age = 0;
            for (int i = 0; i < ND; i++) begin
                m_dig[i] = 4'h0;
                m_en[i]  = 1'b0;
                m_dp[i]  = 1'b0;
            end
        end else begin
            e = model_out();
            if (load) begin
                for (int i = 0; i < ND; i++) begin
                    m_dig[i] = digits_in[4*i +: 4];
                    m_en[i]  = digit_en[i];
                    m_dp[i]  = dp_in[i];
                end
            end
            age++;
        end
        @(posedge clk);
        #1;
        check("anode", 32'(anode), 32'(e.anode));
        check("seg_out", 32'(seg_out), 32'(e.seg));
        check("dp_out", 32'(dp_out), 32'(e.dp));
        check("slot_idx", 32'(slot_idx), 32'(e.slot));
    endtask

    task automatic wait_phase(input int target);
        for (int i = 0; i < 2 * PERIOD && (age % PERIOD) != target; i++) begin
            tick();
        end
        check("align", 32'(age % PERIOD), 32'(target));
    endtask

    initial begin
        int   lit_cnt;
        logic found;

        total = 0;
        bad   = 0;
        age   = 0;
        vecs = '{
            '{4'h0, 7'b0111111}, '{4'h1, 7'b0000110}, '{4'h2, 7'b1011011}, '{4'h3, 7'b1001111},
            '{4'h4, 7'b1100110}, '{4'h5, 7'b1101101}, '{4'h6, 7'b1111101}, '{4'h7, 7'b0000111},
            '{4'h8, 7'b1111111}, '{4'h9, 7'b1101111}, '{4'hA, 7'b1110111}, '{4'hB, 7'b1111100},
            '{4'hC, 7'b0111001}, '{4'hD, 7'b1011110}, '{4'hE, 7'b1111001}, '{4'hF, 7'b1110001}
        };

        rst = 1'b1; load = 1'b0; digits_in = 16'h0; digit_en = 4'h0; dp_in = 4'h0;
        digits1 = 4'h0; en1 = 1'b0; dpin1 = 1'b0; load1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Basic scan of 4321 with every digit enabled
        digits_in = 16'h4321; digit_en = 4'hF; dp_in = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (70) tick();

        // Digits 1 and 3 blanked
        digit_en = 4'b0101; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (40) tick();

        // Decimal point on digit 1 only
        digit_en = 4'hF; dp_in = 4'b0010; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (40) tick();

        // Load on the exact wrap into slot 2
        wait_phase(2 * RD - 1);
        digits_in = 16'hFFFF; load = 1'b1;
        tick();
        load = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (anode == 4'b1011) begin
                found = 1'b1;
                check("wrap_first_glyph", 32'(seg_out), 32'(7'b0001110));
            end
        end
        check("wrap_show_seen", 32'(found), 32'(1'b1));
        repeat (20) tick();

        // Reset pulse mid-SHOW of slot 2
        digits_in = 16'h4321; load = 1'b1;
        tick();
        load = 1'b0;
        wait_phase(2 * RD + 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_anode", 32'(anode), 32'(4'b1111));
        check("rst_slot", 32'(slot_idx), 32'(2'd0));
        lit_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (anode != 4'b1111) lit_cnt++;
        end
        check("blank_after_rst", 32'(lit_cnt), 32'(0));

        // Randomized loads and occasional resets against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            load      = ($urandom_range(0, 5) == 0);
            digits_in = 16'($urandom);
            digit_en  = 4'($urandom);
            dp_in     = 4'($urandom);
            tick();
        end
        rst = 1'b0; load = 1'b0;

        // Active-high single-digit glyph sweep
        for (int v = 0; v < 16; v++) begin
            digits1 = vecs[v].nib; en1 = 1'b1; load1 = 1'b1;
            tick();
            load1 = 1'b0;
            tick();
            lit_cnt = 0;
            for (int k = 0; k < 4; k++) begin
                tick();
                if (anode1) begin
                    lit_cnt++;
                    check("sweep_seg", 32'(seg1), 32'(vecs[v].seg_hi));
                end else begin
                    check("sweep_blank_seg", 32'(seg1), 32'(7'b0000000));
                end
                check("sweep_slot", 32'(slot1), 32'(1'b0));
            end
            check("sweep_duty", 32'(lit_cnt), 32'(3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
